// File: rtl/imem_prog.sv
// rtl/imem_prog.sv - synchronous-read instruction memory with little-endian byte-stream program loader
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, checked on fetch)
module imem_prog #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
  parameter              INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_addr,
  output logic                       fetch_ready,
  output logic                       fetch_rvalid,
  output logic [31:0]                fetch_rdata,
  output logic                       fetch_fault,
  input  logic                       ld_start,
  input  logic [$clog2(DEPTH):0]     ld_len,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_byte,
  output logic                       ld_ready,
  output logic                       ld_busy,
  output logic                       ld_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, state_nx;

  logic [31:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic        par_mem [DEPTH];
`endif

  logic [AW-1:0] ptr;
  logic [1:0]    byte_cnt;
  logic [LW-1:0] len_q;
  // Lanes 0..2 of the word being assembled; lane 3 comes straight from ld_byte
  logic [23:0]   asm_lo;

  logic          byte_acc;
  logic          word_wr;
  logic          last_word;
  logic [31:0]   wr_word;
  logic [LW-1:0] len_eff;

  logic          fetch_acc;
  logic          addr_bad;
  logic          par_bad;
  logic [AW-1:0] fetch_idx;
  logic [31:0]   rd_word;

  assign byte_acc  = ld_valid && ld_ready;
  assign word_wr   = byte_acc && (byte_cnt == 2'd3);
  assign wr_word   = {ld_byte, asm_lo};
  assign last_word = ({1'b0, ptr} == (len_q - LW'(1)));
  // A zero length means the whole memory
  assign len_eff   = (ld_len == '0) ? LW'(DEPTH) : ld_len;

  assign fetch_acc = fetch_req && fetch_ready;
  assign fetch_idx = fetch_addr[AW+1:2];
  assign rd_word   = mem[fetch_idx];
  // Misaligned, or any address bit above the array span set
  assign addr_bad  = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[31:AW+2]);

`ifdef IMEM_PARITY_EN
  assign par_bad = (^rd_word) != par_mem[fetch_idx];
`else
  assign par_bad = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ld_start) state_nx = LOAD;
      LOAD:    if (word_wr && last_word) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    fetch_ready = 1'b0;
    ld_ready    = 1'b0;
    ld_busy     = 1'b0;
    ld_done     = 1'b0;
    case (state)
      IDLE:    fetch_ready = 1'b1;
      LOAD:    begin ld_ready = 1'b1; ld_busy = 1'b1; end
      DONE:    ld_done = 1'b1;
      default: ;
    endcase
  end

  // Loader datapath: length latch, word pointer, byte lane counter, assembly register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      ptr      <= '0;
      byte_cnt <= '0;
      asm_lo   <= '0;
    end else if (state == IDLE && ld_start) begin
      len_q    <= len_eff;
      ptr      <= '0;
      byte_cnt <= '0;
    end else if (byte_acc) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    asm_lo[7:0]   <= ld_byte;
        2'd1:    asm_lo[15:8]  <= ld_byte;
        2'd2:    asm_lo[23:16] <= ld_byte;
        default: ;
      endcase
      if (word_wr) ptr <= ptr + AW'(1);
    end
  end

  // Memory write on the fourth byte of each word; the array itself is never reset
  always @(posedge clk) begin
    if (word_wr) begin
      mem[ptr] <= wr_word;
`ifdef IMEM_PARITY_EN
      par_mem[ptr] <= ^wr_word;
`endif
    end
  end

  // Registered fetch response; rdata holds when no request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_rvalid <= 1'b0;
      fetch_fault  <= 1'b0;
      fetch_rdata  <= NOP_WORD;
    end else begin
      fetch_rvalid <= fetch_acc;
      if (fetch_acc) begin
        if (addr_bad || par_bad) begin
          fetch_rdata <= NOP_WORD;
          fetch_fault <= 1'b1;
        end else begin
          fetch_rdata <= rd_word;
          fetch_fault <= 1'b0;
        end
      end else begin
        fetch_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// tb/tb_imem_prog.sv - scoreboard bench for imem_prog
module tb_imem_prog;

  localparam int          DEPTH = 64;
  localparam int          LW    = 7;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_ready;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          fetch_fault;
  logic          ld_start = 1'b0;
  logic [LW-1:0] ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = '0;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;

  imem_prog #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_fault(fetch_fault),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic f; } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] prog2 [8] = '{8'h93, 8'h00, 8'hf0, 8'h00, 8'h13, 8'h01, 8'h60, 8'h01};
  logic [7:0] prog1 [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0] part6 [6] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented response must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fetch_rvalid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rvalid: got rdata %h with no pending fetch at %0t", fetch_rdata, $time);
        end else begin
          e = q.pop_front();
          chk("sb_rdata", fetch_rdata, e.d);
          chk("sb_fault", 32'(fetch_fault), 32'(e.f));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic f);
    fetch_req  = 1'b1;
    fetch_addr = a;
    q.push_back('{d: d, f: f});
    @(negedge clk);
    fetch_req = 1'b0;
    chk("rvalid_latency", 32'(fetch_rvalid), 1);
    @(negedge clk);
    chk("rvalid_idle", 32'(fetch_rvalid), 0);
    chk("rdata_hold", fetch_rdata, d);
  endtask

  task automatic start(input logic [LW-1:0] len);
    ld_start = 1'b1;
    ld_len   = len;
    @(negedge clk);
    ld_start = 1'b0;
    chk("busy_after_start", 32'(ld_busy), 1);
    chk("ready_after_start", 32'(ld_ready), 1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 32'(fetch_rvalid), 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    chk("rst_rdata", fetch_rdata, NOP);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_ld_busy", 32'(ld_busy), 0);
    chk("rst_ld_done", 32'(ld_done), 0);
    chk("rst_fetch_ready", 32'(fetch_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word load
    start(7'd2);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_byte  = prog2[i];
      @(negedge clk);
      if (i == 6) chk("done_early", 32'(ld_done), 0);
    end
    ld_valid = 1'b0;
    chk("done_pulse", 32'(ld_done), 1);
    chk("busy_in_done", 32'(ld_busy), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(ld_done), 0);
    chk("ready_back_idle", 32'(fetch_ready), 1);

    fetch(32'h0000_0000, 32'h00f0_0093, 1'b0);
    fetch(32'h0000_0004, 32'h0160_0113, 1'b0);
    fetch(32'h0000_0002, NOP, 1'b1);
    fetch(32'h0000_0100, NOP, 1'b1);
    fetch(32'h8000_0000, NOP, 1'b1);
    fetch(32'h0000_0101, NOP, 1'b1);

    // ld_start with a simultaneous fetch; fetch_req then held through the load
    ld_start   = 1'b1;
    ld_len     = 7'd1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    q.push_back('{d: 32'h00f0_0093, f: 1'b0});
    @(negedge clk);
    ld_start = 1'b0;
    ld_len   = 7'd2;
    chk("busy_after_start_fetch", 32'(ld_busy), 1);
    chk("fetch_ready_in_load", 32'(fetch_ready), 0);
    for (int i = 0; i < 4; i++) begin
      ld_start = (i == 1);
      ld_valid = 1'b1;
      ld_byte  = prog1[i];
      @(negedge clk);
      if (i == 2) chk("done_early_len1", 32'(ld_done), 0);
    end
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk("done_len1", 32'(ld_done), 1);
    chk("fetch_ready_in_done", 32'(fetch_ready), 0);
    q.push_back('{d: 32'h1234_5678, f: 1'b0});
    @(negedge clk);
    chk("fetch_ready_after_done", 32'(fetch_ready), 1);
    chk("busy_after_done", 32'(ld_busy), 0);
    @(negedge clk);
    fetch_req = 1'b0;
    chk("rvalid_after_done", 32'(fetch_rvalid), 1);
    @(negedge clk);
    chk("rvalid_after_done_idle", 32'(fetch_rvalid), 0);

    // Reset in the middle of a two-word load
    start(7'd2);
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_byte  = part6[i];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_busy", 32'(ld_busy), 0);
    chk("midrst_ld_ready", 32'(ld_ready), 0);
    chk("midrst_done", 32'(ld_done), 0);
    chk("midrst_rvalid", 32'(fetch_rvalid), 0);
    chk("midrst_fault", 32'(fetch_fault), 0);
    chk("midrst_rdata", fetch_rdata, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h0000_0000, 32'hddcc_bbaa, 1'b0);
    fetch(32'h0000_0004, 32'h0160_0113, 1'b0);

    // Full-depth load with ld_len=0
    start(7'd0);
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 4; k++) begin
        ld_valid = 1'b1;
        case (k)
          0:       ld_byte = 8'(i);
          1:       ld_byte = 8'hc3;
          2:       ld_byte = 8'h3c;
          default: ld_byte = ~8'(i);
        endcase
        if (i == DEPTH - 1 && k == 3) chk("full_not_done_yet", 32'(ld_done), 0);
        @(negedge clk);
      end
    end
    ld_valid = 1'b0;
    chk("full_done", 32'(ld_done), 1);
    @(negedge clk);
    fetch(32'h0000_0000, 32'hff3c_c300, 1'b0);
    fetch(32'h0000_0080, 32'hdf3c_c320, 1'b0);
    fetch(32'h0000_00fc, 32'hc03c_c33f, 1'b0);

`ifdef IMEM_PARITY_EN
    dut.mem[1] = dut.mem[1] ^ 32'h0000_0020;
    fetch(32'h0000_0004, NOP, 1'b1);
    fetch(32'h0000_0008, 32'hfd3c_c302, 1'b0);
`endif

    @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
